// File: rtl/shiftrows_pipe_if.sv
// rtl/shiftrows_pipe_if.sv - stream bundle for shiftrows_pipe; out_par present only with SHIFTROWS_PARITY_EN
interface shiftrows_pipe_if #(
   parameter int SHARES = 5,
   parameter int CELL_W = 4
);
   localparam int DW = SHARES * 16 * CELL_W;

   logic          in_valid;
   logic          in_ready;
   logic          in_dir;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_dir;
   logic [DW-1:0] out_data;
`ifdef SHIFTROWS_PARITY_EN
   logic [SHARES-1:0] out_par;
`endif

   modport slave (
      input  in_valid, in_dir, in_data, out_ready,
`ifdef SHIFTROWS_PARITY_EN
      output out_par,
`endif
      output in_ready, out_valid, out_dir, out_data
   );

   modport master (
      output in_valid, in_dir, in_data, out_ready,
`ifdef SHIFTROWS_PARITY_EN
      input  out_par,
`endif
      input  in_ready, out_valid, out_dir, out_data
   );
endinterface

// File: rtl/shiftrows_pipe.sv
// rtl/shiftrows_pipe.sv - registered share-parallel (inverse) ShiftRows with 2-entry skid buffer; SHIFTROWS_PARITY_EN adds out_par
module shiftrows_pipe #(
   parameter int SHARES = 5,
   parameter int CELL_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   shiftrows_pipe_if.slave   bus
);
   localparam int SW = 16 * CELL_W;
   localparam int DW = SHARES * SW;
`ifdef SHIFTROWS_PARITY_EN
   localparam int EW = DW + 1 + SHARES;
`else
   localparam int EW = DW + 1;
`endif

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} occ_t;

   occ_t          occ_q, occ_d;
   logic [EW-1:0] head_q, head_d;
   logic [EW-1:0] skid_q, skid_d;
   logic [EW-1:0] new_entry;
   logic [DW-1:0] perm_data;
   logic          in_ready_q;
   logic          push, pop;
`ifdef SHIFTROWS_PARITY_EN
   logic [SHARES-1:0] perm_par;
`endif

   // Cell i takes cell i +/- 4*(column+1); rows rotate by a column-dependent amount.
   function automatic logic [SW-1:0] shift_rows(input logic [SW-1:0] st, input logic inv);
      logic [SW-1:0] r;
      int            rot;
      int            src;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         rot = 4 * ((i % 4) + 1);
         src = inv ? (i + 16 - rot) % 16 : (i + rot) % 16;
         r[i*CELL_W +: CELL_W] = st[src*CELL_W +: CELL_W];
      end
      return r;
   endfunction

   // Permute every share independently before it enters the buffer.
   always_comb begin
      perm_data = '0;
`ifdef SHIFTROWS_PARITY_EN
      perm_par  = '0;
`endif
      for (int s = 0; s < SHARES; s++) begin
         perm_data[s*SW +: SW] = shift_rows(bus.in_data[s*SW +: SW], bus.in_dir);
`ifdef SHIFTROWS_PARITY_EN
         perm_par[s] = ^bus.in_data[s*SW +: SW];
`endif
      end
   end

`ifdef SHIFTROWS_PARITY_EN
   assign new_entry = {perm_par, bus.in_dir, perm_data};
   assign bus.out_par = head_q[DW+1 +: SHARES];
`else
   assign new_entry = {bus.in_dir, perm_data};
`endif

   // in_ready is a flop; rst only forces it low during the reset cycle itself.
   assign bus.in_ready  = in_ready_q & ~rst;
   assign bus.out_valid = (occ_q != S_EMPTY);
   assign bus.out_data  = head_q[DW-1:0];
   assign bus.out_dir   = head_q[DW];

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   // Occupancy next-state and head/skid updates; a push while full cannot happen.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      skid_d = skid_q;
      case (occ_q)
         S_EMPTY: begin
            if (push) begin
               head_d = new_entry;
               occ_d  = S_ONE;
            end
         end
         S_ONE: begin
            if (push && pop) begin
               head_d = new_entry;
            end else if (push) begin
               skid_d = new_entry;
               occ_d  = S_FULL;
            end else if (pop) begin
               occ_d  = S_EMPTY;
            end
         end
         S_FULL: begin
            if (pop) begin
               head_d = skid_q;
               occ_d  = S_ONE;
            end
         end
         default: occ_d = S_EMPTY;
      endcase
   end

   // State and storage registers; reset drops both entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q      <= S_EMPTY;
         head_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         occ_q      <= occ_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= (occ_d != S_FULL);
      end
   end
endmodule

// File: tb/tb_shiftrows_pipe.sv
// tb/tb_shiftrows_pipe.sv - randomized self-checking bench for shiftrows_pipe (SHIFTROWS_PARITY_EN selects the 3x8 parity build)
module tb_shiftrows_pipe;
`ifdef SHIFTROWS_PARITY_EN
   localparam int SH = 3;
   localparam int CW = 8;
`else
   localparam int SH = 5;
   localparam int CW = 4;
`endif
   localparam int SW = 16 * CW;
   localparam int DW = SH * SW;

   typedef logic [DW-1:0] data_t;
   typedef struct packed {
      logic  dir;
      data_t data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shiftrows_pipe_if #(.SHARES(SH), .CELL_W(CW)) bus ();
   shiftrows_pipe #(.SHARES(SH), .CELL_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   ent_t  sbq[$];
   int    nvec = 0;
   int    nmis = 0;
   int    maxn;
   int    npop;
   int    nacc;
   logic  last_acc, last_pop, last_dir;
   data_t last_out;

   // in_dir must be known whenever a beat is offered.
   always @(posedge clk)
      if (bus.in_valid === 1'b1)
         assert (!$isunknown(bus.in_dir)) else $error("in_dir unknown with in_valid high");

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: lane c holds cells c, c+4, c+8, c+12; forward rotates the lane by c+1 toward lower rows.
   function automatic data_t ref_perm(input data_t d, input logic inv);
      data_t r;
      logic [CW-1:0] lane[$];
      r = '0;
      for (int s = 0; s < SH; s++) begin
         for (int c = 0; c < 4; c++) begin
            lane.delete();
            for (int j = 0; j < 4; j++) lane.push_back(d[s*SW + (4*j + c)*CW +: CW]);
            for (int k = 0; k < (c + 1) % 4; k++) begin
               if (inv) lane.push_front(lane.pop_back());
               else     lane.push_back(lane.pop_front());
            end
            for (int j = 0; j < 4; j++) r[s*SW + (4*j + c)*CW +: CW] = lane[j];
         end
      end
      return r;
   endfunction

`ifdef SHIFTROWS_PARITY_EN
   function automatic logic [SH-1:0] ref_par(input data_t d);
      logic [SH-1:0] p;
      for (int s = 0; s < SH; s++) p[s] = ^d[s*SW +: SW];
      return p;
   endfunction
`endif

   function automatic data_t rnd();
      data_t r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // One cycle: inputs were set at the negedge; sample 1 ns later, update the model, move to next negedge.
   task automatic cyc();
      ent_t e;
      #1;
      last_acc = bus.in_valid && bus.in_ready;
      last_pop = bus.out_valid && bus.out_ready && !rst;
      last_out = bus.out_data;
      last_dir = bus.out_dir;
      if (!rst) begin
         chk("out_valid", bus.out_valid, sbq.size() != 0);
         chk("in_ready", bus.in_ready, sbq.size() < 2);
         if (sbq.size() > maxn) maxn = sbq.size();
`ifdef SHIFTROWS_PARITY_EN
         if (bus.out_valid) chk("out_par", bus.out_par, ref_par(bus.out_data));
`endif
         if (last_pop) begin
            if (sbq.size() == 0) begin
               chk("spurious_out", bus.out_valid, 1'b0);
            end else begin
               e = sbq.pop_front();
               chk("out_data", bus.out_data, e.data);
               chk("out_dir", bus.out_dir, e.dir);
`ifdef SHIFTROWS_PARITY_EN
               chk("out_par_sb", bus.out_par, ref_par(e.data));
`endif
               npop++;
            end
         end
         if (last_acc) begin
            e.dir  = bus.in_dir;
            e.data = ref_perm(bus.in_data, bus.in_dir);
            sbq.push_back(e);
            nacc++;
         end
      end else begin
         chk("in_ready_rst", bus.in_ready, 1'b0);
      end
      @(negedge clk);
   endtask

   task automatic xfer(input logic dir, input data_t d, output data_t r);
      int n;
      bus.in_valid  = 1'b1;
      bus.in_dir    = dir;
      bus.in_data   = d;
      bus.out_ready = 1'b1;
      n = 0;
      do begin cyc(); n++; end while (!last_acc && n < 8);
      chk("xfer_acc", last_acc, 1'b1);
      bus.in_valid = 1'b0;
      n = 0;
      do begin cyc(); n++; end while (!last_pop && n < 8);
      chk("xfer_pop", last_pop, 1'b1);
      r = last_out;
   endtask

   initial begin
      data_t d, f, b, orig;
      maxn = 0; npop = 0; nacc = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_dir = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

      // reset
      @(negedge clk);
      cyc();
      rst = 1'b0;
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_out_dir", bus.out_dir, 1'b0);
      cyc();

      // directed forward vector, one-cycle latency
      d = '0;
      d[63:0] = 64'hFEDC_BA98_7654_3210;
      bus.in_valid = 1'b1; bus.in_dir = 1'b0; bus.in_data = d; bus.out_ready = 1'b1;
      cyc();
      chk("dir_acc", last_acc, 1'b1);
      bus.in_valid = 1'b0;
      cyc();
      chk("latency_pop", last_pop, 1'b1);
`ifndef SHIFTROWS_PARITY_EN
      chk("fwd_share0", last_out[63:0], 64'hFA50_B61C_72D8_3E94);
      chk("fwd_share1", last_out[127:64], 64'h0);
`endif

      // round trip
      for (int v = 0; v < 1000; v++) begin
         orig = rnd();
         xfer(1'b0, orig, f);
         chk("rt_dir0", last_dir, 1'b0);
         xfer(1'b1, f, b);
         chk("rt_dir1", last_dir, 1'b1);
         chk("roundtrip", b, orig);
      end
      cyc();

      // backpressure
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_dir = 1'($urandom_range(1)); bus.in_data = rnd();
      cyc();
      chk("bp_acc0", last_acc, 1'b1);
      bus.in_dir = 1'($urandom_range(1)); bus.in_data = rnd();
      cyc();
      chk("bp_acc1", last_acc, 1'b1);
      bus.in_dir = 1'($urandom_range(1)); bus.in_data = rnd();
      cyc();
      chk("bp_full", last_acc, 1'b0);
      chk("bp_hold", last_out, sbq[0].data);
      cyc();
      chk("bp_hold2", last_out, sbq[0].data);
      bus.out_ready = 1'b1;
      cyc();
      chk("bp_pop_ready", last_acc, 1'b0);
      cyc();
      chk("bp_reopen", last_acc, 1'b1);
      chk("bp_pop2", last_pop, 1'b1);
      bus.in_valid = 1'b0;
      cyc();
      chk("bp_pop3", last_pop, 1'b1);
      cyc();

      // streaming
      npop = 0; nacc = 0; maxn = 0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      repeat (100) begin
         bus.in_dir = 1'($urandom_range(1)); bus.in_data = rnd();
         cyc();
      end
      bus.in_valid = 1'b0;
      cyc();
      chk("stream_acc", nacc, 100);
      chk("stream_out", npop, 100);
      chk("stream_maxN", maxn, 1);

      // reset mid-operation
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.in_dir = 1'($urandom_range(1)); bus.in_data = rnd();
      cyc();
      bus.in_dir = 1'($urandom_range(1)); bus.in_data = rnd();
      cyc();
      chk("mid_full", sbq.size(), 2);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      sbq.delete();
      chk("mid_out_data", bus.out_data, '0);
      chk("mid_out_dir", bus.out_dir, 1'b0);
      bus.out_ready = 1'b1;
      repeat (4) cyc();

      // random mixed traffic
      for (int k = 0; k < 300; k++) begin
         bus.in_valid  = 1'($urandom_range(1));
         bus.out_ready = 1'($urandom_range(1));
         bus.in_dir    = 1'($urandom_range(1));
         bus.in_data   = rnd();
         cyc();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (4) cyc();
      chk("drain_empty", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
